// File: rtl/fc_argmax.sv
// Classification head: tracks the largest IEEE-754 binary32 score in each frame of
// OUTPUT_NUM serial beats and reports its arrival index and original bit pattern.
module fc_argmax #(
    parameter int OUTPUT_NUM = 512,
    parameter int DATA_BITS  = 32,
    parameter int IDX_BITS   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 valid_out,
    output logic [IDX_BITS-1:0]  max_idx,
    output logic [DATA_BITS-1:0] max_val,
    output logic                 busy
);

    localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(OUTPUT_NUM - 1);
    localparam logic [IDX_BITS-1:0]  IDX_ZERO = {IDX_BITS{1'b0}};
    localparam logic [IDX_BITS-1:0]  IDX_ONE  = IDX_BITS'(1);
    localparam logic [DATA_BITS-1:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_nan(input logic [DATA_BITS-1:0] bits);
        return (bits[30:23] == 8'hFF) && (bits[22:0] != 23'd0);
    endfunction

    // Monotonic unsigned key: -0 folds onto +0 so the two tie and the earlier wins.
    function automatic logic [DATA_BITS-1:0] order_key(input logic [DATA_BITS-1:0] bits);
        logic [DATA_BITS-1:0] norm;
        norm = (bits == 32'h8000_0000) ? 32'h0000_0000 : bits;
        return norm[31] ? ~norm : {1'b1, norm[30:0]};
    endfunction

    state_t               state_r, state_s;
    logic [IDX_BITS-1:0]  cnt_r, cnt_s;
    logic                 have_r, have_s;
    logic [DATA_BITS-1:0] best_key_r, best_key_s;
    logic [IDX_BITS-1:0]  best_idx_r, best_idx_s;
    logic [DATA_BITS-1:0] best_val_r, best_val_s;
    logic                 valid_out_r, valid_out_s;
    logic [IDX_BITS-1:0]  max_idx_r, max_idx_s;
    logic [DATA_BITS-1:0] max_val_r, max_val_s;
    logic                 busy_r, busy_s;

    logic                 first_s;
    logic                 last_s;
    logic                 beat_nan_s;
    logic [DATA_BITS-1:0] beat_key_s;
    logic                 take_s;

    // Beat classification: frame position and whether this beat beats the held best.
    always_comb begin
        first_s    = (state_r == IDLE);
        last_s     = (cnt_r == LAST_IDX);
        beat_nan_s = is_nan(data_in);
        beat_key_s = order_key(data_in);
        if (valid_in && !beat_nan_s) begin
            take_s = first_s || !have_r || (beat_key_s > best_key_r);
        end else begin
            take_s = 1'b0;
        end
    end

    // Frame FSM next-state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_in) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (valid_in && last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Best-so-far tracking, beat counter and result capture.
    always_comb begin
        cnt_s       = cnt_r;
        have_s      = have_r;
        best_key_s  = best_key_r;
        best_idx_s  = best_idx_r;
        best_val_s  = best_val_r;
        valid_out_s = 1'b0;
        max_idx_s   = max_idx_r;
        max_val_s   = max_val_r;
        if (valid_in) begin
            if (take_s) begin
                have_s     = 1'b1;
                best_key_s = beat_key_s;
                best_idx_s = cnt_r;
                best_val_s = data_in;
            end else if (first_s) begin
                // A NaN opening beat still wipes the previous frame's best.
                have_s     = 1'b0;
                best_key_s = {DATA_BITS{1'b0}};
                best_idx_s = IDX_ZERO;
                best_val_s = {DATA_BITS{1'b0}};
            end else begin
                have_s = have_r;
            end
            if (last_s) begin
                cnt_s       = IDX_ZERO;
                valid_out_s = 1'b1;
                max_idx_s   = have_s ? best_idx_s : IDX_ZERO;
                max_val_s   = have_s ? best_val_s : QNAN;
            end else begin
                cnt_s = cnt_r + IDX_ONE;
            end
        end else begin
            cnt_s = cnt_r;
        end
        busy_s = (cnt_s != IDX_ZERO);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= IDX_ZERO;
            have_r      <= 1'b0;
            best_key_r  <= {DATA_BITS{1'b0}};
            best_idx_r  <= IDX_ZERO;
            best_val_r  <= {DATA_BITS{1'b0}};
            valid_out_r <= 1'b0;
            max_idx_r   <= IDX_ZERO;
            max_val_r   <= {DATA_BITS{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            have_r      <= have_s;
            best_key_r  <= best_key_s;
            best_idx_r  <= best_idx_s;
            best_val_r  <= best_val_s;
            valid_out_r <= valid_out_s;
            max_idx_r   <= max_idx_s;
            max_val_r   <= max_val_s;
            busy_r      <= busy_s;
        end
    end

    assign valid_out = valid_out_r;
    assign max_idx   = max_idx_r;
    assign max_val   = max_val_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fc_argmax.sv
// Bench for fc_argmax: an 8-score instance driven from a vector table plus reset abort,
// and a 512-score instance fed two back-to-back frames with random gaps.
module tb_fc_argmax;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v8, v5;
    logic [31:0] d8, d5;
    logic        vo8, vo5;
    logic [9:0]  mi8, mi5;
    logic [31:0] mv8, mv5;
    logic        b8, b5;

    int passed   = 0;
    int total    = 0;
    int edge_cnt = 0;
    int cnt8     = 0;
    int cnt5     = 0;

    typedef struct packed {
        logic [9:0]  idx;
        logic [31:0] val;
        logic [31:0] due;
    } exp_t;

    typedef struct packed {
        logic [0:7][31:0] s;
        logic [9:0]       idx;
        logic [31:0]      val;
    } vec_t;

    exp_t        q8[$];
    exp_t        q5[$];
    exp_t        e8, e5;
    logic [9:0]  hold_idx8 = 10'd0, hold_idx5 = 10'd0;
    logic [31:0] hold_val8 = 32'd0, hold_val5 = 32'd0;
    vec_t        tbl[7];
    logic [31:0] fa[512];
    logic [31:0] fb[512];
    logic [31:0] abort_s[8];
    logic [31:0] fresh_s[8];

    fc_argmax #(.OUTPUT_NUM(8), .DATA_BITS(32), .IDX_BITS(10)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid_in(v8), .data_in(d8),
        .valid_out(vo8), .max_idx(mi8), .max_val(mv8), .busy(b8)
    );

    fc_argmax #(.OUTPUT_NUM(512), .DATA_BITS(32), .IDX_BITS(10)) dut512 (
        .clk(clk), .rst_n(rst_n), .valid_in(v5), .data_in(d5),
        .valid_out(vo5), .max_idx(mi5), .max_val(mv5), .busy(b5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic push8(input logic [9:0] idx, input logic [31:0] val);
        q8.push_back('{idx: idx, val: val, due: 32'(edge_cnt + 1)});
    endtask

    task automatic push5(input logic [9:0] idx, input logic [31:0] val);
        q5.push_back('{idx: idx, val: val, due: 32'(edge_cnt + 1)});
    endtask

    // One clock: drive both instances, then check busy against the bench's beat counts.
    task automatic step(input logic a8, input logic [31:0] x8, input logic a5, input logic [31:0] x5);
        v8 = a8; d8 = x8; v5 = a5; d5 = x5;
        @(posedge clk);
        #1;
        if (a8 && rst_n) cnt8 = (cnt8 == 7) ? 0 : cnt8 + 1;
        if (a5 && rst_n) cnt5 = (cnt5 == 511) ? 0 : cnt5 + 1;
        chk("busy8", {63'd0, b8}, {63'd0, cnt8 != 0});
        chk("busy512", {63'd0, b5}, {63'd0, cnt5 != 0});
    endtask

    function automatic logic [31:0] rnd_score(input int max_exp);
        int          r;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        w = $urandom;
        if (r == 0) return {w[31], 8'hFF, 1'b1, w[21:0]};
        else if (r < 4) return {1'b1, w[30:0]};
        else return {1'b0, 8'($urandom_range(0, max_exp)), w[22:0]};
    endfunction

    // Scoreboard: pulses pop the queue; between pulses the outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_idx8 = 10'd0; hold_val8 = 32'd0;
            hold_idx5 = 10'd0; hold_val5 = 32'd0;
        end else begin
            if (vo8) begin
                if (q8.size() == 0) chk("spurious_pulse8", {63'd0, vo8}, 64'd0);
                else begin
                    e8 = q8.pop_front();
                    chk("max_idx8", {54'd0, mi8}, {54'd0, e8.idx});
                    chk("max_val8", {32'd0, mv8}, {32'd0, e8.val});
                    chk("latency8", 64'(edge_cnt), {32'd0, e8.due});
                    hold_idx8 = e8.idx; hold_val8 = e8.val;
                end
            end else begin
                chk("hold_idx8", {54'd0, mi8}, {54'd0, hold_idx8});
                chk("hold_val8", {32'd0, mv8}, {32'd0, hold_val8});
            end
            if (vo5) begin
                if (q5.size() == 0) chk("spurious_pulse512", {63'd0, vo5}, 64'd0);
                else begin
                    e5 = q5.pop_front();
                    chk("max_idx512", {54'd0, mi5}, {54'd0, e5.idx});
                    chk("max_val512", {32'd0, mv5}, {32'd0, e5.val});
                    chk("latency512", 64'(edge_cnt), {32'd0, e5.due});
                    hold_idx5 = e5.idx; hold_val5 = e5.val;
                end
            end else begin
                chk("hold_idx512", {54'd0, mi5}, {54'd0, hold_idx5});
                chk("hold_val512", {32'd0, mv5}, {32'd0, hold_val5});
            end
        end
    end

    initial begin
        tbl[0] = '{s: {32'h3F800000, 32'h40400000, 32'h40000000, 32'hC0A00000,
                       32'h3F000000, 32'h40200000, 32'h00000000, 32'h3FC00000},
                   idx: 10'd1, val: 32'h40400000};
        tbl[1] = '{s: {8{32'h40000000}}, idx: 10'd0, val: 32'h40000000};
        tbl[2] = '{s: {32'hFF800000, 32'hBF800000, 32'h80000000, 32'h7FC00000,
                       32'h00000000, 32'hC0000000, 32'h7FC00000, 32'hC0400000},
                   idx: 10'd2, val: 32'h80000000};
        tbl[3] = '{s: {32'h7FC00000, 32'hFFC00000, 32'h7F800001, 32'hFFFFFFFF,
                       32'h7FC00000, 32'h7FC00001, 32'hFF800001, 32'h7FFFFFFF},
                   idx: 10'd0, val: 32'h7FC00000};
        tbl[4] = '{s: {32'h00000001, 32'hBF800000, 32'h7F7FFFFF, 32'h7FFFFFFF,
                       32'hC2C80000, 32'h7F800000, 32'h7F800000, 32'h00000000},
                   idx: 10'd5, val: 32'h7F800000};
        tbl[5] = '{s: {32'hC0000000, 32'hC1000000, 32'hFF800000, 32'hC0400000,
                       32'hC0800000, 32'hFF7FFFFF, 32'hC0A00000, 32'hBF000000},
                   idx: 10'd7, val: 32'hBF000000};
        tbl[6] = '{s: {32'h7FC00000, 32'hC0400000, 32'hC0800000, 32'hC0000000,
                       32'hFF800000, 32'h7FC00001, 32'hC0A00000, 32'hC0C00000},
                   idx: 10'd3, val: 32'hC0000000};
        abort_s = '{32'h4E6E6B28, 32'h7F800000, 32'h3F800000, 32'h40000000,
                    32'h40400000, 32'h0, 32'h0, 32'h0};
        fresh_s = '{32'h3F800000, 32'h40000000, 32'hC0000000, 32'h7FC00000,
                    32'h40400000, 32'h3F000000, 32'h41200000, 32'h40800000};
        for (int i = 0; i < 512; i++) begin
            fa[i] = (i == 511) ? 32'h4E6E6B28 : rnd_score(150);
            fb[i] = (i == 0)   ? 32'h40E00000 : rnd_score(128);
        end

        rst_n = 1'b0;
        v8 = 1'b0; d8 = 32'd0; v5 = 1'b0; d5 = 32'd0;
        repeat (2) step(1'b0, 32'd0, 1'b0, 32'd0);
        chk("rst_valid_out8", {63'd0, vo8}, 64'd0);
        chk("rst_max_idx8", {54'd0, mi8}, 64'd0);
        chk("rst_max_val8", {32'd0, mv8}, 64'd0);
        chk("rst_valid_out512", {63'd0, vo5}, 64'd0);
        chk("rst_max_val512", {32'd0, mv5}, 64'd0);
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b0, 32'd0);

        // Table frames back-to-back: each first beat lands on the previous pulse cycle.
        for (int t = 0; t < 7; t++) begin
            for (int j = 0; j < 8; j++) begin
                if (j == 7) push8(tbl[t].idx, tbl[t].val);
                step(1'b1, tbl[t].s[j], 1'b0, 32'd0);
            end
        end
        repeat (3) step(1'b0, 32'd0, 1'b0, 32'd0);

        // Abort a frame after beat 4, then a fresh frame with its max at index 6.
        for (int j = 0; j < 5; j++) step(1'b1, abort_s[j], 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy8", {63'd0, b8}, 64'd0);
        chk("abort_max_idx8", {54'd0, mi8}, 64'd0);
        chk("abort_max_val8", {32'd0, mv8}, 64'd0);
        cnt8 = 0;
        step(1'b0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b0, 32'd0);
        for (int j = 0; j < 8; j++) begin
            if (j == 7) push8(10'd6, 32'h41200000);
            step(1'b1, fresh_s[j], 1'b0, 32'd0);
        end
        repeat (3) step(1'b0, 32'd0, 1'b0, 32'd0);

        // Two 512-beat frames with random gaps, B starting right after A's last beat.
        for (int i = 0; i < 512; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step(1'b0, 32'd0, 1'b0, 32'd0);
            if (i == 511) push5(10'd511, 32'h4E6E6B28);
            step(1'b0, 32'd0, 1'b1, fa[i]);
        end
        for (int i = 0; i < 512; i++) begin
            if (i != 0 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step(1'b0, 32'd0, 1'b0, 32'd0);
            if (i == 511) push5(10'd0, 32'h40E00000);
            step(1'b0, 32'd0, 1'b1, fb[i]);
        end
        repeat (4) step(1'b0, 32'd0, 1'b0, 32'd0);

        chk("pending8", 64'(q8.size()), 64'd0);
        chk("pending512", 64'(q5.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
